// File: rtl/alu_exec_stage_if.sv
// Decode-to-writeback handshake bundle for the execute-stage ALU.
// The slave modport is the ALU's view; the master modport is the surrounding pipeline's view.
interface alu_exec_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              iValid;
  logic              oReady;
  logic [4:0]        iOp;
  logic [XLEN-1:0]   iOpA;
  logic [XLEN-1:0]   iOpB;
  logic [XLEN-1:0]   iImm;
  logic              iUseImm;
  logic [XLEN-1:0]   iPc;
  logic [REG_AW-1:0] iRd;
  logic              iFlush;
  logic              oValid;
  logic              iReady;
  logic [XLEN-1:0]   oResult;
  logic [REG_AW-1:0] oRd;
  logic              oBrTaken;
  logic              oMemReq;
  logic              oIllegal;

  modport slave (
    input  iValid, iOp, iOpA, iOpB, iImm, iUseImm, iPc, iRd, iFlush, iReady,
    output oReady, oValid, oResult, oRd, oBrTaken, oMemReq, oIllegal
  );

  modport master (
    output iValid, iOp, iOpA, iOpB, iImm, iUseImm, iPc, iRd, iFlush, iReady,
    input  oReady, oValid, oResult, oRd, oBrTaken, oMemReq, oIllegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: arithmetic/logic, branch resolution and AGEN with a 1-cycle registered output.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (opcode 18, XLEN busy cycles).
module alu_exec_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic             iClk,
  input logic             iRst,
  alu_exec_stage_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_LUI  = 5'd10;
  localparam logic [4:0] OP_AGEN = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12;
  localparam logic [4:0] OP_BNE  = 5'd13;
  localparam logic [4:0] OP_BLT  = 5'd14;
  localparam logic [4:0] OP_BGE  = 5'd15;
  localparam logic [4:0] OP_BLTU = 5'd16;
  localparam logic [4:0] OP_BGEU = 5'd17;
`ifdef ALU_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'd18;
`endif

  logic [XLEN-1:0]   result_q, result_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              br_q, br_d;
  logic              mem_q, mem_d;
  logic              ill_q, ill_d;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(XLEN - 1);

  state_t            state_q, state_d;
  logic [SHAMT_W:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
`endif

  logic [XLEN-1:0]   op_a, op_b, op_b_reg;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]   alu_res;
  logic [REG_AW-1:0] alu_rd;
  logic              alu_br, alu_mem, alu_ill, is_mul;
  logic              ready, accept;

  assign op_a     = bus.iOpA;
  assign op_b_reg = bus.iOpB;
  assign op_b     = bus.iUseImm ? bus.iImm : bus.iOpB;
  assign shamt    = op_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_rd  = bus.iRd;
    alu_br  = 1'b0;
    alu_mem = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (bus.iOp)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_LUI:  alu_res = op_b;
      OP_AGEN: begin
        alu_res = op_a + bus.iImm;
        alu_mem = 1'b1;
      end
      // Branches always compare against rs2, regardless of iUseImm
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_res = bus.iPc + bus.iImm;
        alu_rd  = '0;
        case (bus.iOp)
          OP_BEQ:  alu_br = (op_a == op_b_reg);
          OP_BNE:  alu_br = (op_a != op_b_reg);
          OP_BLT:  alu_br = ($signed(op_a) < $signed(op_b_reg));
          OP_BGE:  alu_br = ($signed(op_a) >= $signed(op_b_reg));
          OP_BLTU: alu_br = (op_a < op_b_reg);
          default: alu_br = (op_a >= op_b_reg);
        endcase
      end
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: begin
        alu_ill = 1'b1;
        alu_rd  = '0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  assign ready = (state_q == S_IDLE) && (!valid_q || bus.iReady);
`else
  assign ready = !valid_q || bus.iReady;
`endif
  assign accept = bus.iValid && ready && !bus.iFlush;

  always_comb begin
    result_d = result_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    br_d     = br_q;
    mem_d    = mem_q;
    ill_d    = ill_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    if (bus.iFlush) begin
      valid_d = 1'b0;
      br_d    = 1'b0;
      mem_d   = 1'b0;
      ill_d   = 1'b0;
`ifdef ALU_MUL_EN
      state_d = S_IDLE;
      cnt_d   = '0;
`endif
    end else if (accept) begin
      rd_d = alu_rd;
      br_d = alu_br;
      mem_d = alu_mem;
      ill_d = alu_ill;
`ifdef ALU_MUL_EN
      if (is_mul) begin
        // result_q doubles as the product accumulator while busy
        state_d  = S_MUL;
        cnt_d    = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        result_d = '0;
        valid_d  = 1'b0;
      end else begin
        result_d = alu_res;
        valid_d  = 1'b1;
      end
`else
      result_d = alu_res;
      valid_d  = 1'b1;
`endif
`ifdef ALU_MUL_EN
    end else if (state_q == S_MUL) begin
      result_d = result_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
`endif
    end else if (valid_q && bus.iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      result_q <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      br_q     <= 1'b0;
      mem_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      result_q <= result_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      br_q     <= br_d;
      mem_q    <= mem_d;
      ill_q    <= ill_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  // Unused in non-MUL builds; kept so both builds share one decoder
  logic unused_is_mul;
  assign unused_is_mul = is_mul;

  assign bus.oReady   = ready;
  assign bus.oValid   = valid_q;
  assign bus.oResult  = result_q;
  assign bus.oRd      = rd_q;
  assign bus.oBrTaken = br_q;
  assign bus.oMemReq  = mem_q;
  assign bus.oIllegal = ill_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage; expected values are hand-computed.
// The MUL section is compiled only when ALU_MUL_EN is defined.
module tb_alu_exec_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic iClk;
  logic iRst;
  int   checks;
  int   failures;

  alu_exec_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  alu_exec_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic use_imm, input logic [31:0] pc,
                        input logic [4:0] rd);
    bus.iOp     = op;
    bus.iOpA    = a;
    bus.iOpB    = b;
    bus.iImm    = imm;
    bus.iUseImm = use_imm;
    bus.iPc     = pc;
    bus.iRd     = rd;
    bus.iValid  = 1'b1;
  endtask

  // Present one op for one edge, then leave the result on the outputs
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic [31:0] pc,
                       input logic [4:0] rd);
    set_op(op, a, b, imm, use_imm, pc, rd);
    tick();
    bus.iValid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    iRst = 1'b1;
    bus.iValid = 1'b0; bus.iOp = '0; bus.iOpA = '0; bus.iOpB = '0; bus.iImm = '0;
    bus.iUseImm = 1'b0; bus.iPc = '0; bus.iRd = '0; bus.iFlush = 1'b0; bus.iReady = 1'b1;
    tick(); tick();
    iRst = 1'b0;
    check_eq("rst_valid", bus.oValid, 0);
    check_eq("rst_result", bus.oResult, 0);
    check_eq("rst_flags", {bus.oBrTaken, bus.oMemReq, bus.oIllegal, bus.oRd}, 0);
    check_eq("rst_ready", bus.oReady, 1);

    issue(5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd3);
    check_eq("add_valid", bus.oValid, 1);
    check_eq("add_result", bus.oResult, 32'h8000_0000);
    check_eq("add_rd", bus.oRd, 3);
    issue(5'd1, 32'd0, 32'd1, 32'd0, 1'b0, 32'd0, 5'd4);
    check_eq("sub_result", bus.oResult, 32'hFFFF_FFFF);
    issue(5'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'd0, 5'd5);
    check_eq("sra_result", bus.oResult, 32'hF800_0000);
    issue(5'd6, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'd0, 5'd5);
    check_eq("srl_result", bus.oResult, 32'h0800_0000);
    issue(5'd2, 32'h0000_0003, 32'd0, 32'd31, 1'b1, 32'd0, 5'd5);
    check_eq("sll_result", bus.oResult, 32'h8000_0000);
    issue(5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd6);
    check_eq("slt_result", bus.oResult, 1);
    issue(5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd6);
    check_eq("sltu_result", bus.oResult, 0);
    issue(5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0, 32'd0, 5'd7);
    check_eq("xor_result", bus.oResult, 32'hFF00_EDCB);
    issue(5'd8, 32'hF000_0001, 32'h0000_0F00, 32'd0, 1'b0, 32'd0, 5'd7);
    check_eq("or_result", bus.oResult, 32'hF000_0F01);
    issue(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 32'd0, 5'd7);
    check_eq("and_result", bus.oResult, 32'hF000_F000);
    issue(5'd10, 32'h1111_1111, 32'd0, 32'hABCD_E000, 1'b1, 32'd0, 5'd8);
    check_eq("lui_result", bus.oResult, 32'hABCD_E000);

    // Branches: iUseImm=1 must not affect the rs2 comparison
    issue(5'd14, 32'hFFFF_FFFE, 32'd3, 32'h20, 1'b1, 32'h100, 5'd9);
    check_eq("blt_taken", bus.oBrTaken, 1);
    check_eq("blt_target", bus.oResult, 32'h120);
    check_eq("blt_rd", bus.oRd, 0);
    issue(5'd17, 32'hFFFF_FFFE, 32'd3, 32'h20, 1'b1, 32'h100, 5'd9);
    check_eq("bgeu_taken", bus.oBrTaken, 1);
    issue(5'd12, 32'd5, 32'd6, 32'h8, 1'b0, 32'h200, 5'd9);
    check_eq("beq_taken", bus.oBrTaken, 0);
    check_eq("beq_target", bus.oResult, 32'h208);

    issue(5'd11, 32'h1000, 32'd0, 32'hFFFF_FFFC, 1'b0, 32'd0, 5'd10);
    check_eq("agen_result", bus.oResult, 32'hFFC);
    check_eq("agen_memreq", bus.oMemReq, 1);
    bus.iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_valid", bus.oValid, 1);
      check_eq("bp_result", bus.oResult, 32'hFFC);
      check_eq("bp_memreq", bus.oMemReq, 1);
      check_eq("bp_ready", bus.oReady, 0);
    end
    set_op(5'd0, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, 5'd11);
    bus.iReady = 1'b1;
    #1;
    check_eq("bp_release_ready", bus.oReady, 1);
    tick();
    bus.iValid = 1'b0;
    check_eq("bp_add_result", bus.oResult, 11);
    check_eq("bp_add_memreq", bus.oMemReq, 0);

    for (int i = 0; i < 4; i++) begin
      set_op(5'd0, 32'd100 + 32'(i), 32'd1000, 32'd0, 1'b0, 32'd0, 5'(i + 1));
      tick();
      check_eq("b2b_valid", bus.oValid, 1);
      check_eq("b2b_result", bus.oResult, 32'd1100 + 32'(i));
      check_eq("b2b_rd", bus.oRd, i + 1);
    end
    bus.iValid = 1'b0;
    tick();
    check_eq("idle_valid", bus.oValid, 0);

    set_op(5'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0, 5'd12);
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    bus.iValid = 1'b0;
    check_eq("flush_drop_valid", bus.oValid, 0);

    issue(5'd25, 32'd1, 32'd2, 32'd3, 1'b0, 32'd4, 5'd13);
    check_eq("ill_valid", bus.oValid, 1);
    check_eq("ill_flag", bus.oIllegal, 1);
    check_eq("ill_result", bus.oResult, 0);
    check_eq("ill_rd", bus.oRd, 0);

`ifdef ALU_MUL_EN
    begin
      int n;
      issue(5'd18, 32'd7, 32'd6, 32'd0, 1'b0, 32'd0, 5'd14);
      check_eq("mul_busy_valid", bus.oValid, 0);
      check_eq("mul_busy_ready", bus.oReady, 0);
      n = 1;
      while (!bus.oValid && n < 200) begin
        tick();
        n++;
      end
      check_eq("mul_latency", n, XLEN + 1);
      check_eq("mul_result", bus.oResult, 42);
      check_eq("mul_rd", bus.oRd, 14);
      tick();
      issue(5'd18, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0, 5'd15);
      for (int i = 0; i < 4; i++) tick();
      bus.iFlush = 1'b1;
      tick();
      bus.iFlush = 1'b0;
      check_eq("mul_flush_valid", bus.oValid, 0);
      check_eq("mul_flush_ready", bus.oReady, 1);
      for (int i = 0; i < XLEN + 2; i++) begin
        tick();
        if (bus.oValid) check_eq("mul_flush_stray_valid", bus.oValid, 0);
      end
    end
`else
    issue(5'd18, 32'd7, 32'd6, 32'd0, 1'b0, 32'd0, 5'd14);
    check_eq("op18_illegal", bus.oIllegal, 1);
    check_eq("op18_valid", bus.oValid, 1);
    check_eq("op18_ready", bus.oReady, 1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Parametrised execute-stage ALU for the core pipeline; successor to the single-opcode load ALU.
- Sits between the decode stage and the memory/writeback stage, with a valid/ready handshake on both sides.
- Covers integer arithmetic and logic, branch resolution and load/store address generation.
- Registered output with 1-cycle latency; an optional iterative multiplier adds a multi-cycle busy state.

Parameters:
- XLEN, 32, datapath width in bits; power of two, minimum 8.
- REG_AW, 5, destination register address width.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iValid  in  1  input operation valid.
- oReady  out  1  stage can accept an operation this cycle.
- iOp  in  5  operation code (list under Behaviour).
- iOpA  in  XLEN  rs1 value.
- iOpB  in  XLEN  rs2 value.
- iImm  in  XLEN  sign-extended immediate.
- iUseImm  in  1  1: operand B = iImm; 0: operand B = iOpB.
- iPc  in  XLEN  PC of the instruction.
- iRd  in  REG_AW  destination register address.
- iFlush  in  1  kill the in-flight operation and any operation presented this cycle.
- oValid  out  1  output result valid.
- iReady  in  1  downstream accepts the result.
- oResult  out  XLEN  ALU result, memory address for AGEN, or branch target.
- oRd  out  REG_AW  destination register address, 0 for branches.
- oBrTaken  out  1  branch condition true (branch ops only).
- oMemReq  out  1  result is a load/store address.
- oIllegal  out  1  unsupported opcode received.

Behaviour:
- Operand B is iImm when iUseImm=1, otherwise iOpB. Shift ops use B[SHAMT_W-1:0].
- Opcodes and results:
  - 0 ADD: A+B. 1 SUB: A-B. 2 SLL: A shifted left. 3 SLT: signed A<B, result 1 or 0.
  - 4 SLTU: unsigned A<B. 5 XOR. 6 SRL: logical right shift. 7 SRA: arithmetic right shift.
  - 8 OR. 9 AND. 10 LUI: result = B. 11 AGEN: A+iImm, sets oMemReq=1.
  - 12 BEQ, 13 BNE, 14 BLT, 15 BGE, 16 BLTU, 17 BGEU: compare A against iOpB (ignores iUseImm); oResult = iPc+iImm; oBrTaken = condition; oRd = 0.
  - 18 MUL: only with the optional feature. 19-31: illegal.
- All arithmetic is modulo 2^XLEN; no overflow flag.
- Handshake: accept when iValid && oReady && !iFlush. oReady = (state==IDLE) && (!oValid || iReady).
- Non-MUL ops: outputs registered; oValid rises on the cycle after accept.
- Outputs hold stable while oValid && !iReady (back-pressure). A new op may be accepted in the same cycle the old result is taken, giving back-to-back throughput of 1 per cycle.
- Illegal opcode: oValid=1, oIllegal=1, oResult=0, oRd=0, oBrTaken=0, oMemReq=0.
- FSM states:
  - IDLE: accepting.
  - MUL: iterative multiply busy, oReady=0. Entered when a MUL op is accepted; returns to IDLE with oValid=1 when the step counter expires.
- iFlush: the same cycle, clears oValid and all flags, aborts MUL (state -> IDLE, counter cleared), and drops any op presented that cycle. Flush has priority over accept and over iReady.
- Reset values: oValid=0, oResult=0, oRd=0, oBrTaken=0, oMemReq=0, oIllegal=0, state IDLE, counter 0. After iRst deasserts, oReady=1 on the first cycle. Reset asserted mid-MUL aborts the multiply.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Opcode 18 MUL is legal; oResult = lower XLEN bits of A*B.
  - Implemented as shift-add, one multiplier bit per cycle. The accept cycle is followed by XLEN busy cycles; oValid rises XLEN+1 cycles after accept.
  - iReady is ignored during MUL.
- Not defined:
  - Opcode 18 is illegal; no MUL state or counter is synthesised.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=1 -> next cycle oValid=1, oResult=0x80000000; SUB A=0, B=1 -> 0xFFFFFFFF.
- SRA A=0x80000000, iUseImm=1, iImm=4 -> 0xF8000000; SRL with the same operands -> 0x08000000; SLT A=-1, B=1 -> 1; SLTU with the same operands -> 0.
- BLT A=-2, B=3, iPc=0x100, iImm=0x20 -> oBrTaken=1, oResult=0x120, oRd=0; BGEU with the same operands -> oBrTaken=1.
- AGEN A=0x1000, iImm=-4 -> oResult=0xFFC, oMemReq=1. Hold iReady=0 for 3 cycles -> outputs stable and oReady=0. Then iReady=1 with a new ADD presented -> ADD is accepted in that same cycle.
- Back-to-back ADDs with iReady=1 for 4 cycles -> 4 results on consecutive cycles. iFlush together with iValid -> op dropped, oValid=0 next cycle.
- With ALU_MUL_EN: MUL 7*6 -> oResult=42 at cycle XLEN+1 after accept. A second MUL flushed at busy cycle 5 -> no oValid, oReady=1 the next cycle. Without ALU_MUL_EN: opcode 18 -> oIllegal=1.
